// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - command encodings and FSM states for the histogram bin store
package hist_pkg;

    typedef enum logic [1:0] {
        CMD_ACQ   = 2'b00,
        CMD_CLEAR = 2'b01,
        CMD_IDLE  = 2'b10,
        CMD_READ  = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACQ,
        ST_CLEAR,
        ST_READ,
        ST_DONE
    } state_e;

endpackage

// File: rtl/hist_ram.sv
// rtl/hist_ram.sv - 1R1W synchronous-read bin RAM, read-first on address collision
module hist_ram #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/hist_bin_memory.sv
// rtl/hist_bin_memory.sv - histogram bin store: hit counting, clear sweep, ready/valid readout
module hist_bin_memory
    import hist_pkg::*;
#(
    parameter int N_BINS      = 128,
    parameter int ADDR_W      = $clog2(N_BINS),
    parameter int CNT_W       = 32,
    parameter bit SATURATE    = 1'b1,
    parameter bit CLR_ON_READ = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        cmd,
    input  logic              hit_valid,
    input  logic [ADDR_W-1:0] hit_bin,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic              busy,
    output logic              overflow
);

    state_e state, state_nx;

    logic [ADDR_W-1:0] clr_addr;
    logic              s1_valid;
    logic [ADDR_W-1:0] s1_bin;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_bin;
    logic [CNT_W-1:0]  wb_data;
    logic [CNT_W-1:0]  base, inc;
    logic              inc_ovf;

    logic [ADDR_W:0]   issue_cnt;
    logic              f_valid;
    logic [ADDR_W-1:0] f_addr;
    logic [ADDR_W-1:0] out_bin;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [CNT_W-1:0]  ram_wdata, ram_rdata;

    logic hit_take, clr_last, beat_acc, last_acc, out_free, f_adv, read_run;

    assign hit_take = (state == ST_ACQ) && (cmd == CMD_ACQ) && hit_valid;
    assign clr_last = (state == ST_CLEAR) && (clr_addr == ADDR_W'(N_BINS - 1));
    assign beat_acc = rd_valid && rd_ready;
    assign last_acc = beat_acc && rd_last;
    assign out_free = !rd_valid || rd_ready;
    assign f_adv    = !f_valid || out_free;
    assign read_run = (state == ST_READ) && (cmd == CMD_READ);
    assign busy     = (state == ST_CLEAR) || s1_valid;

    // The RAM read issued in S0 misses the write retiring on that same edge; take it from wb_*.
    assign base    = (wb_valid && (wb_bin == s1_bin)) ? wb_data : ram_rdata;
    assign inc_ovf = &base;
    assign inc     = inc_ovf ? (SATURATE ? base : '0) : base + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                case (cmd)
                    CMD_ACQ:   state_nx = ST_ACQ;
                    CMD_CLEAR: state_nx = ST_CLEAR;
                    CMD_READ:  state_nx = ST_READ;
                    default:   state_nx = ST_IDLE;
                endcase
            end
            ST_ACQ:   if (cmd != CMD_ACQ && !s1_valid) state_nx = ST_IDLE;
            ST_CLEAR: if (clr_last) state_nx = ST_IDLE;
            ST_READ: begin
                if (cmd != CMD_READ) begin
                    state_nx = (cmd == CMD_CLEAR) ? ST_CLEAR : ST_IDLE;
                end else if (last_acc) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE:  if (cmd != CMD_READ) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Exactly one write source per state, so the single RAM write port needs no arbiter.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = s1_bin;
        ram_wdata = inc;
        ram_raddr = hit_bin;
        case (state)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr;
                ram_wdata = '0;
            end
            ST_ACQ: ram_we = s1_valid;
            ST_READ: begin
                ram_raddr = f_adv ? issue_cnt[ADDR_W-1:0] : f_addr;
                ram_we    = CLR_ON_READ && beat_acc;
                ram_waddr = out_bin;
                ram_wdata = '0;
            end
            default: ram_we = 1'b0;
        endcase
    end

    hist_ram #(
        .DEPTH (N_BINS),
        .ADDR_W(ADDR_W),
        .DATA_W(CNT_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(ram_raddr),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_addr  <= '0;
            s1_valid  <= 1'b0;
            s1_bin    <= '0;
            wb_valid  <= 1'b0;
            wb_bin    <= '0;
            wb_data   <= '0;
            overflow  <= 1'b0;
            issue_cnt <= '0;
            f_valid   <= 1'b0;
            f_addr    <= '0;
            out_bin   <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_last   <= 1'b0;
        end else begin
            clr_addr <= (state == ST_CLEAR) ? clr_addr + 1'b1 : '0;
            s1_valid <= hit_take;
            s1_bin   <= hit_bin;
            wb_valid <= s1_valid;
            wb_bin   <= s1_bin;
            wb_data  <= inc;

            if (clr_last) begin
                overflow <= 1'b0;
            end else if (s1_valid && inc_ovf) begin
                overflow <= 1'b1;
            end

            // While the output stalls, the fetch stage re-reads f_addr so RAM data stays valid.
            if (read_run) begin
                if (f_adv) begin
                    f_valid <= !issue_cnt[ADDR_W];
                    f_addr  <= issue_cnt[ADDR_W-1:0];
                    if (!issue_cnt[ADDR_W]) begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                end
                if (last_acc) begin
                    rd_valid <= 1'b0;
                    rd_last  <= 1'b0;
                end else if (out_free) begin
                    rd_valid <= f_valid;
                    rd_last  <= f_valid && (&f_addr);
                    if (f_valid) begin
                        rd_data <= ram_rdata;
                        out_bin <= f_addr;
                    end
                end
            end else begin
                issue_cnt <= '0;
                f_valid   <= 1'b0;
                rd_valid  <= 1'b0;
                rd_last   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hist_bin_memory.sv
// tb/tb_hist_bin_memory.sv - directed bench for hist_bin_memory across three parameter sets
module tb_hist_bin_memory;
    import hist_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] cmd;
    logic       hit_valid;
    logic [6:0] hit_bin;
    logic       rd_ready;

    logic [31:0] m_data;
    logic        m_valid, m_last, m_busy, m_ovf;
    logic [3:0]  s_data;
    logic        s_valid, s_last, s_busy, s_ovf;
    logic [7:0]  c_data;
    logic        c_valid, c_last, c_busy, c_ovf;

    int tests = 0;
    int fails = 0;
    int exp_main[128];
    int exp_sat[8];
    int exp_cor[8];
    int hits[$];

    hist_bin_memory u_main (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .hit_valid(hit_valid), .hit_bin(hit_bin),
        .rd_data(m_data), .rd_valid(m_valid), .rd_ready(rd_ready), .rd_last(m_last),
        .busy(m_busy), .overflow(m_ovf)
    );

    hist_bin_memory #(.N_BINS(8), .CNT_W(4), .SATURATE(1'b1), .CLR_ON_READ(1'b0)) u_sat (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .hit_valid(hit_valid), .hit_bin(hit_bin[2:0]),
        .rd_data(s_data), .rd_valid(s_valid), .rd_ready(rd_ready), .rd_last(s_last),
        .busy(s_busy), .overflow(s_ovf)
    );

    hist_bin_memory #(.N_BINS(8), .CNT_W(8), .SATURATE(1'b1), .CLR_ON_READ(1'b1)) u_cor (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .hit_valid(hit_valid), .hit_bin(hit_bin[2:0]),
        .rd_data(c_data), .rd_valid(c_valid), .rd_ready(rd_ready), .rd_last(c_last),
        .busy(c_busy), .overflow(c_ovf)
    );

    task automatic clear_models();
        foreach (exp_main[i]) exp_main[i] = 0;
        foreach (exp_sat[i]) exp_sat[i] = 0;
        foreach (exp_cor[i]) exp_cor[i] = 0;
    endtask

    task automatic do_acq();
        hit_valid = 1'b1;
        hit_bin   = 7'd20;
        cmd       = CMD_IDLE;
        @(negedge clk);
        hit_valid = 1'b0;
        cmd       = CMD_ACQ;
        @(negedge clk);
        foreach (hits[i]) begin
            hit_valid = 1'b1;
            hit_bin   = 7'(hits[i]);
            exp_main[hits[i]]++;
            if (exp_sat[hits[i] % 8] != 15) exp_sat[hits[i] % 8]++;
            exp_cor[hits[i] % 8]++;
            @(negedge clk);
        end
        hit_bin = 7'd20;
        cmd     = CMD_IDLE;
        @(negedge clk);
        hit_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_clear(input string tag);
        for (int i = 0; i < 300 && m_busy; i++) @(negedge clk);
        tests++;
        if (m_busy !== 1'b0) begin
            fails++;
            $display("FAIL %s busy: got %0b expected 0", tag, m_busy);
        end
    endtask

    task automatic read_stream(input int rmode, input int abort_after);
        int mi, si, ci, first, lastc;
        logic r, pst;
        logic [31:0] pd;
        mi = 0; si = 0; ci = 0; first = -1; lastc = 0; pst = 1'b0; pd = '0;
        cmd = CMD_READ;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (pst) begin
                tests++;
                if (m_valid !== 1'b1 || m_data !== pd) begin
                    fails++;
                    $display("FAIL stall_hold: got valid %0b data %0d expected valid 1 data %0d", m_valid, m_data, pd);
                end
            end
            r = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            rd_ready = r;
            if (m_valid && r && mi < 128) begin
                tests++;
                if (m_data !== 32'(exp_main[mi]) || m_last !== (mi == 127)) begin
                    fails++;
                    $display("FAIL main_beat %0d: got data %0d last %0b expected data %0d last %0b",
                             mi, m_data, m_last, exp_main[mi], (mi == 127));
                end
                if (first < 0) first = cyc;
                lastc = cyc;
                mi++;
            end
            if (s_valid && r && si < 8) begin
                tests++;
                if (s_data !== 4'(exp_sat[si]) || s_last !== (si == 7)) begin
                    fails++;
                    $display("FAIL sat_beat %0d: got data %0d last %0b expected data %0d last %0b",
                             si, s_data, s_last, exp_sat[si], (si == 7));
                end
                si++;
            end
            if (c_valid && r && ci < 8) begin
                tests++;
                if (c_data !== 8'(exp_cor[ci]) || c_last !== (ci == 7)) begin
                    fails++;
                    $display("FAIL cor_beat %0d: got data %0d last %0b expected data %0d last %0b",
                             ci, c_data, c_last, exp_cor[ci], (ci == 7));
                end
                exp_cor[ci] = 0;
                ci++;
            end
            pst = m_valid && !r;
            pd  = m_data;
            if (abort_after > 0 && mi == abort_after) break;
            if (abort_after == 0 && mi == 128 && si == 8 && ci == 8) break;
        end
        if (abort_after > 0) begin
            cmd = CMD_ACQ;
            @(negedge clk);
            tests++;
            if (m_valid !== 1'b0 || m_last !== 1'b0) begin
                fails++;
                $display("FAIL abort: got valid %0b last %0b expected 0 0", m_valid, m_last);
            end
        end else begin
            tests++;
            if (mi != 128 || si != 8 || ci != 8) begin
                fails++;
                $display("FAIL beat_count: got %0d/%0d/%0d expected 128/8/8", mi, si, ci);
            end
            if (rmode == 0) begin
                tests++;
                if (lastc - first != 127) begin
                    fails++;
                    $display("FAIL no_bubble: got span %0d expected 127", lastc - first);
                end
            end
            @(negedge clk);
            tests++;
            if (m_valid !== 1'b0) begin
                fails++;
                $display("FAIL done_valid: got %0b expected 0", m_valid);
            end
        end
        cmd = CMD_IDLE;
        rd_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        int mb, sb, cb;
        rst_n = 1'b0; cmd = CMD_IDLE; hit_valid = 1'b0; hit_bin = '0; rd_ready = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (m_data !== 32'd0 || m_valid !== 1'b0 || m_last !== 1'b0 || m_ovf !== 1'b0 || m_busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_outputs: got data %0d valid %0b last %0b ovf %0b busy %0b expected 0 0 0 0 1",
                     m_data, m_valid, m_last, m_ovf, m_busy);
        end
        rst_n = 1'b1;
        mb = 0; sb = 0; cb = 0;
        for (int i = 0; i < 200; i++) begin
            if (m_busy) mb++;
            if (s_busy) sb++;
            if (c_busy) cb++;
            @(negedge clk);
        end
        tests++;
        if (mb != 128 || sb != 8 || cb != 8) begin
            fails++;
            $display("FAIL auto_clear_busy: got %0d/%0d/%0d expected 128/8/8", mb, sb, cb);
        end
        clear_models();
    endtask

    task automatic test_read_zero();
        read_stream(0, 0);
    endtask

    task automatic test_acq_forward();
        hits = {5, 5, 5, 9, 7, 7};
        do_acq();
        tests++;
        if (m_ovf !== 1'b0 || s_ovf !== 1'b0) begin
            fails++;
            $display("FAIL acq_overflow: got %0b/%0b expected 0/0", m_ovf, s_ovf);
        end
        read_stream(0, 0);
    endtask

    task automatic test_back_to_back_backpressure();
        read_stream(1, 0);
    endtask

    task automatic test_saturation();
        hits = {};
        for (int i = 0; i < 20; i++) hits.push_back(2);
        do_acq();
        tests++;
        if (s_ovf !== 1'b1 || m_ovf !== 1'b0) begin
            fails++;
            $display("FAIL sat_overflow: got sat %0b main %0b expected 1 0", s_ovf, m_ovf);
        end
        read_stream(0, 0);
        cmd = CMD_CLEAR;
        @(negedge clk);
        cmd = CMD_IDLE;
        wait_clear("clear_cmd");
        tests++;
        if (s_ovf !== 1'b0) begin
            fails++;
            $display("FAIL clear_overflow: got %0b expected 0", s_ovf);
        end
        clear_models();
        read_stream(0, 0);
    endtask

    task automatic test_abort();
        hits = {3, 100, 100, 127};
        do_acq();
        read_stream(0, 10);
        read_stream(0, 0);
    endtask

    task automatic test_reset_mid_acq();
        cmd = CMD_ACQ;
        @(negedge clk);
        hit_valid = 1'b1;
        hit_bin   = 7'd4;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (m_data !== 32'd0 || m_valid !== 1'b0 || m_ovf !== 1'b0 || m_busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset: got data %0d valid %0b ovf %0b busy %0b expected 0 0 0 1",
                     m_data, m_valid, m_ovf, m_busy);
        end
        hit_valid = 1'b0;
        cmd = CMD_IDLE;
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear("mid_reset_clear");
        clear_models();
        read_stream(0, 0);
    endtask

    initial begin
        test_reset();
        test_read_zero();
        test_acq_forward();
        test_back_to_back_backpressure();
        test_saturation();
        test_abort();
        test_reset_mid_acq();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
